// File: rtl/register_adder_hold_multi.sv
// Adder hold register: captures ALU sum/carry/overflow, drives split tristate buses.
// Ports: clk, reset, data_in, carry_in, overflow_in, load, restore,
//   bus_enable_lo/hi, data_out (inout, NUM_BUSES*WIDTH), carry_out,
//   overflow_out, state.
// Optional macro ADD_HOLD_RESTORE_EN enables the one-deep restore history.
module register_adder_hold_multi #(
    parameter int WIDTH     = 8,
    parameter int NUM_BUSES = 2,
    parameter int SPLIT_BIT = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       carry_in,
    input  logic                       overflow_in,
    input  logic                       load,
    input  logic                       restore,
    input  logic [NUM_BUSES-1:0]       bus_enable_lo,
    input  logic [NUM_BUSES-1:0]       bus_enable_hi,
    inout  wire  [NUM_BUSES*WIDTH-1:0] data_out,
    output logic                       carry_out,
    output logic                       overflow_out,
    output logic [1:0]                 state
);

    localparam int HI_W = WIDTH - SPLIT_BIT;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FULL     = 2'd1,
        CONSUMED = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] held;
    logic             do_restore;
    logic             any_read;

    assign any_read = |{bus_enable_lo, bus_enable_hi};

`ifdef ADD_HOLD_RESTORE_EN
    logic [WIDTH-1:0] prev;
    logic             prev_carry;
    logic             prev_overflow;

    // load beats restore when both are asserted
    assign do_restore = restore & ~load;

    always_ff @(posedge clk) begin
        if (reset) begin
            held          <= '0;
            carry_out     <= 1'b0;
            overflow_out  <= 1'b0;
            prev          <= '0;
            prev_carry    <= 1'b0;
            prev_overflow <= 1'b0;
        end else if (load) begin
            held          <= data_in;
            carry_out     <= carry_in;
            overflow_out  <= overflow_in;
            prev          <= held;
            prev_carry    <= carry_out;
            prev_overflow <= overflow_out;
        end else if (do_restore) begin
            held          <= prev;
            carry_out     <= prev_carry;
            overflow_out  <= prev_overflow;
        end
    end
`else
    logic unused_restore;

    assign unused_restore = restore;
    assign do_restore     = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            held         <= '0;
            carry_out    <= 1'b0;
            overflow_out <= 1'b0;
        end else if (load) begin
            held         <= data_in;
            carry_out    <= carry_in;
            overflow_out <= overflow_in;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A read coinciding with a load never marks the fresh value consumed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (load) begin
                    state_d = FULL;
                end else if (any_read) begin
                    state_d = CONSUMED;
                end else if (do_restore) begin
                    state_d = FULL;
                end
            end
            CONSUMED: begin
                if (load || do_restore) begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign state = state_q;

    for (genvar b = 0; b < NUM_BUSES; b++) begin : g_bus
        assign data_out[b*WIDTH +: SPLIT_BIT] =
            bus_enable_lo[b] ? held[SPLIT_BIT-1:0] : {SPLIT_BIT{1'bz}};
        assign data_out[b*WIDTH+SPLIT_BIT +: HI_W] =
            bus_enable_hi[b] ? held[WIDTH-1:SPLIT_BIT] : {HI_W{1'bz}};
    end

endmodule
